// File: rtl/seg_serial_decoder.sv
// ---------------------------------------------------------------------------
// seg_serial_decoder
//
// Receive-side monitor for the serial seven-segment display link. A frame of
// DIGITS segment bytes is shifted in one bit at a time, most significant bit
// of the highest digit first. The frame is then decoded back into hex digits,
// one digit per cycle through a single shared glyph lookup. Each byte is laid
// out {p,g,f,e,d,c,b,a}.
//
// Parameters
//   DIGITS      number of digits per frame (frame is 8*DIGITS bits)
//   ACTIVE_LOW  1 = segments/point are low-true on the link, 0 = high-true
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   seg_shift  strobe: sample seg_dat as the next frame bit
//   seg_dat    serial segment data
//   seg_load   strobe: end of frame, latch and decode
//   hex        decoded digits, digit i at hex[4i+3:4i]
//   points     decimal point lit, per digit
//   blank      all seven segments dark, per digit
//   invalid    pattern is neither a hex glyph nor blank, per digit
//   valid      one-cycle pulse: hex/points/blank/invalid just updated
//   frame_err  one-cycle pulse: seg_load with wrong bit count
//   overrun    one-cycle pulse: seg_shift or seg_load while busy
//   busy       high while a frame is being decoded
// ---------------------------------------------------------------------------
module seg_serial_decoder #(
    parameter int DIGITS     = 8,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  seg_shift,
    input  logic                  seg_dat,
    input  logic                  seg_load,
    output logic [4*DIGITS-1:0]   hex,
    output logic [DIGITS-1:0]     points,
    output logic [DIGITS-1:0]     blank,
    output logic [DIGITS-1:0]     invalid,
    output logic                  valid,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int NBITS = 8 * DIGITS;
    // One extra code above NBITS so a too-long frame stays distinguishable.
    localparam int CW    = $clog2(NBITS + 2);
    localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {
        IDLE,
        DECODE
    } state_t;

    state_t                 state_q;
    logic [NBITS-1:0]       sr_q;
    logic [NBITS-1:0]       sr_d;
    logic [CW-1:0]          bitCnt_q;
    logic [CW-1:0]          bitCnt_d;
    logic [NBITS-1:0]       frameBuf_q;
    logic [IW-1:0]          digitIdx_q;
    logic                   commitPend_q;

    logic [4*DIGITS-1:0]    hexStage_q;
    logic [DIGITS-1:0]      pointsStage_q;
    logic [DIGITS-1:0]      blankStage_q;
    logic [DIGITS-1:0]      invalidStage_q;

    logic [4*DIGITS-1:0]    hex_q;
    logic [DIGITS-1:0]      points_q;
    logic [DIGITS-1:0]      blank_q;
    logic [DIGITS-1:0]      invalid_q;
    logic                   valid_q;
    logic                   frameErr_q;
    logic                   overrun_q;
    logic                   busy_q;

    logic                   loadOk;
    logic [7:0]             rawByte;
    logic [7:0]             litByte;
    logic [4:0]             glyph;
    logic [3:0]             digitHex;
    logic                   digitPoint;
    logic                   digitBlank;
    logic                   digitInvalid;

    // Maps a lit-high gfedcba pattern to {match, hex value}; no match -> 0.
    function automatic logic [4:0] lookupGlyph(input logic [6:0] seg);
        logic [4:0] result;
        case (seg)
            7'h3F:   result = {1'b1, 4'h0};
            7'h06:   result = {1'b1, 4'h1};
            7'h5B:   result = {1'b1, 4'h2};
            7'h4F:   result = {1'b1, 4'h3};
            7'h66:   result = {1'b1, 4'h4};
            7'h6D:   result = {1'b1, 4'h5};
            7'h7D:   result = {1'b1, 4'h6};
            7'h07:   result = {1'b1, 4'h7};
            7'h7F:   result = {1'b1, 4'h8};
            7'h6F:   result = {1'b1, 4'h9};
            7'h77:   result = {1'b1, 4'hA};
            7'h7C:   result = {1'b1, 4'hB};
            7'h39:   result = {1'b1, 4'hC};
            7'h5E:   result = {1'b1, 4'hD};
            7'h79:   result = {1'b1, 4'hE};
            7'h71:   result = {1'b1, 4'hF};
            default: result = 5'b0_0000;
        endcase
        return result;
    endfunction

    // Shift register and bit counter next state. Only the idle state accepts
    // bits; a shift in the same cycle as a load is applied first, so the
    // length check below already includes that bit.
    always_comb begin
        sr_d     = sr_q;
        bitCnt_d = bitCnt_q;
        if (state_q == IDLE && seg_shift) begin
            sr_d = {sr_q[NBITS-2:0], seg_dat};
            if (bitCnt_q != CW'(NBITS + 1)) begin
                bitCnt_d = bitCnt_q + CW'(1);
            end
        end
    end

    assign loadOk = (bitCnt_d == CW'(NBITS));

    // Shared per-digit decode of the frame byte selected by the digit index.
    // Blank is checked before the glyph table so an all-dark pattern never
    // reports invalid; the point bit is carried through independently.
    always_comb begin
        rawByte      = frameBuf_q[{digitIdx_q, 3'b000} +: 8];
        litByte      = ACTIVE_LOW ? ~rawByte : rawByte;
        glyph        = lookupGlyph(litByte[6:0]);
        digitPoint   = litByte[7];
        digitBlank   = (litByte[6:0] == 7'h00);
        digitInvalid = !digitBlank && !glyph[4];
        digitHex     = glyph[4] ? glyph[3:0] : 4'h0;
    end

    // Control FSM plus all registered state and outputs. The commit of the
    // staging registers happens one cycle after the last digit is staged,
    // which gives the DIGITS+1 cycle load-to-valid latency while busy only
    // covers the DIGITS decode cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            sr_q           <= '0;
            bitCnt_q       <= '0;
            frameBuf_q     <= '0;
            digitIdx_q     <= '0;
            commitPend_q   <= 1'b0;
            hexStage_q     <= '0;
            pointsStage_q  <= '0;
            blankStage_q   <= '0;
            invalidStage_q <= '0;
            hex_q          <= '0;
            points_q       <= '0;
            blank_q        <= '1;
            invalid_q      <= '0;
            valid_q        <= 1'b0;
            frameErr_q     <= 1'b0;
            overrun_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            valid_q    <= 1'b0;
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;

            if (commitPend_q) begin
                hex_q        <= hexStage_q;
                points_q     <= pointsStage_q;
                blank_q      <= blankStage_q;
                invalid_q    <= invalidStage_q;
                valid_q      <= 1'b1;
                commitPend_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    sr_q     <= sr_d;
                    bitCnt_q <= bitCnt_d;
                    if (seg_load) begin
                        bitCnt_q <= '0;
                        if (loadOk) begin
                            frameBuf_q <= sr_d;
                            digitIdx_q <= '0;
                            state_q    <= DECODE;
                            busy_q     <= 1'b1;
                        end else begin
                            frameErr_q <= 1'b1;
                        end
                    end
                end

                DECODE: begin
                    if (seg_shift || seg_load) begin
                        overrun_q <= 1'b1;
                    end
                    hexStage_q[{digitIdx_q, 2'b00} +: 4] <= digitHex;
                    pointsStage_q[digitIdx_q]            <= digitPoint;
                    blankStage_q[digitIdx_q]             <= digitBlank;
                    invalidStage_q[digitIdx_q]           <= digitInvalid;
                    if (digitIdx_q == IW'(DIGITS - 1)) begin
                        state_q      <= IDLE;
                        busy_q       <= 1'b0;
                        commitPend_q <= 1'b1;
                    end else begin
                        digitIdx_q <= digitIdx_q + IW'(1);
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign hex       = hex_q;
    assign points    = points_q;
    assign blank     = blank_q;
    assign invalid   = invalid_q;
    assign valid     = valid_q;
    assign frame_err = frameErr_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_seg_serial_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg_serial_decoder
//
// Self-checking bench for seg_serial_decoder with DIGITS=8, ACTIVE_LOW=1.
// A table of frames with their expected decode is driven in a loop; each
// accepted load pushes its expectation onto a scoreboard queue, and a monitor
// pops and compares whenever valid pulses (including the exact latency).
// Hand-written sequences cover bad frame lengths, coincident shift/load,
// overrun during decode and reset in the middle of a decode.
// ---------------------------------------------------------------------------
module tb_seg_serial_decoder;

    localparam int DIGITS = 8;

    logic                 clk;
    logic                 rst;
    logic                 seg_shift;
    logic                 seg_dat;
    logic                 seg_load;
    logic [4*DIGITS-1:0]  hex;
    logic [DIGITS-1:0]    points;
    logic [DIGITS-1:0]    blank;
    logic [DIGITS-1:0]    invalid;
    logic                 valid;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    typedef struct {
        logic [63:0] frame;
        logic [31:0] expHex;
        logic [7:0]  expPoints;
        logic [7:0]  expBlank;
        logic [7:0]  expInvalid;
    } vector_t;

    typedef struct {
        logic [31:0] hex;
        logic [7:0]  points;
        logic [7:0]  blank;
        logic [7:0]  invalid;
        int          cycle;
    } exp_t;

    vector_t vecs [4];
    exp_t    sbQ  [$];
    int      checks   = 0;
    int      errors   = 0;
    int      cycleCnt = 0;

    seg_serial_decoder #(
        .DIGITS     (DIGITS),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_shift (seg_shift),
        .seg_dat   (seg_dat),
        .seg_load  (seg_load),
        .hex       (hex),
        .points    (points),
        .blank     (blank),
        .invalid   (invalid),
        .valid     (valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    // 10 ns clock and a rising-edge counter used to time the valid pulse.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycleCnt++;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every valid pulse must match the oldest pending
    // expectation, on exactly the expected cycle.
    always @(negedge clk) begin
        if (!rst && valid) begin
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_valid: got valid at cycle %0d, expected none", cycleCnt);
            end else begin
                exp_t e;
                e = sbQ.pop_front();
                checkOutput("valid_latency", cycleCnt, e.cycle);
                checkOutput("hex", hex, e.hex);
                checkOutput("points", {24'h0, points}, {24'h0, e.points});
                checkOutput("blank", {24'h0, blank}, {24'h0, e.blank});
                checkOutput("invalid", {24'h0, invalid}, {24'h0, e.invalid});
            end
        end
    end

    // Shifts nBits of the frame MSB first; the load is either coincident
    // with the last bit or in the following cycle. Returns at the negedge
    // right after the load was sampled.
    task automatic shiftFrame(input logic [63:0] frame, input int nBits,
                              input bit coincident, input bit pushExp,
                              input exp_t e);
        exp_t ex;
        ex = e;
        for (int i = 0; i < nBits; i++) begin
            seg_shift = 1'b1;
            seg_dat   = frame[63 - (i % 64)];
            seg_load  = coincident && (i == nBits - 1);
            if (seg_load && pushExp) begin
                ex.cycle = cycleCnt + DIGITS + 2;
                sbQ.push_back(ex);
            end
            @(negedge clk);
        end
        seg_shift = 1'b0;
        seg_dat   = 1'b0;
        if (!coincident) begin
            seg_load = 1'b1;
            if (pushExp) begin
                ex.cycle = cycleCnt + DIGITS + 2;
                sbQ.push_back(ex);
            end
            @(negedge clk);
        end
        seg_load = 1'b0;
    endtask

    function automatic exp_t toExp(input vector_t v);
        exp_t e;
        e.hex     = v.expHex;
        e.points  = v.expPoints;
        e.blank   = v.expBlank;
        e.invalid = v.expInvalid;
        e.cycle   = 0;
        return e;
    endfunction

    // Full well-formed frame: checks busy width, no frame error, the
    // scoreboard has drained, and the outputs then hold.
    task automatic applyStimulus(input vector_t v, input bit coincident);
        int busyCnt;
        int errCnt;
        busyCnt = 0;
        errCnt  = 0;
        shiftFrame(v.frame, 64, coincident, 1'b1, toExp(v));
        for (int c = 0; c < 12; c++) begin
            if (busy) busyCnt++;
            if (frame_err) errCnt++;
            @(negedge clk);
        end
        checkOutput("busy_cycles", busyCnt, 8);
        checkOutput("no_frame_err", errCnt, 0);
        checkOutput("sb_drain", sbQ.size(), 0);
        checkOutput("hex_hold", hex, v.expHex);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t dummy;
        dummy = '{hex: 32'h0, points: 8'h0, blank: 8'h0, invalid: 8'h0, cycle: 0};

        vecs[0] = '{frame: 64'hC0F9A4B0999282F8, expHex: 32'h01234567,
                    expPoints: 8'h00, expBlank: 8'h00, expInvalid: 8'h00};
        vecs[1] = '{frame: 64'h80908883C6A1860E, expHex: 32'h89ABCDEF,
                    expPoints: 8'h01, expBlank: 8'h00, expInvalid: 8'h00};
        vecs[2] = '{frame: 64'hC0C07FC0FFC0AAC0, expHex: 32'h00000000,
                    expPoints: 8'h20, expBlank: 8'h28, expInvalid: 8'h02};
        vecs[3] = '{frame: 64'h4079243019120278, expHex: 32'h01234567,
                    expPoints: 8'hFF, expBlank: 8'h00, expInvalid: 8'h00};

        rst       = 1'b1;
        seg_shift = 1'b0;
        seg_dat   = 1'b0;
        seg_load  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        checkOutput("rst_hex", hex, 32'h0);
        checkOutput("rst_points", {24'h0, points}, 32'h0);
        checkOutput("rst_blank", {24'h0, blank}, 32'hFF);
        checkOutput("rst_invalid", {24'h0, invalid}, 32'h0);
        checkOutput("rst_flags", {valid, frame_err, overrun, busy}, 4'b0000);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i], 1'b0);
        end

        // Short frame: error pulse, no valid, outputs unchanged.
        shiftFrame(vecs[0].frame, 63, 1'b0, 1'b0, dummy);
        checkOutput("frame_err_63", frame_err, 1'b1);
        checkOutput("busy_after_63", busy, 1'b0);
        @(negedge clk);
        checkOutput("frame_err_width", frame_err, 1'b0);
        repeat (12) @(negedge clk);
        checkOutput("hold_after_63", hex, vecs[3].expHex);
        checkOutput("hold_pts_63", {24'h0, points}, 32'hFF);

        // Long frame: counter saturates past the legal length.
        shiftFrame(vecs[1].frame, 65, 1'b0, 1'b0, dummy);
        checkOutput("frame_err_65", frame_err, 1'b1);
        repeat (12) @(negedge clk);
        checkOutput("hold_after_65", hex, vecs[3].expHex);

        // Load coincident with the 64th bit.
        applyStimulus(vecs[1], 1'b1);

        // Load and shift while decoding: overrun pulses, result unaffected.
        shiftFrame(vecs[0].frame, 64, 1'b0, 1'b1, toExp(vecs[0]));
        @(negedge clk);
        seg_load = 1'b1;
        @(negedge clk);
        seg_load = 1'b0;
        checkOutput("overrun_load", overrun, 1'b1);
        @(negedge clk);
        checkOutput("overrun_width", overrun, 1'b0);
        seg_shift = 1'b1;
        seg_dat   = 1'b1;
        @(negedge clk);
        seg_shift = 1'b0;
        seg_dat   = 1'b0;
        checkOutput("overrun_shift", overrun, 1'b1);
        repeat (10) @(negedge clk);
        checkOutput("overrun_drain", sbQ.size(), 0);
        checkOutput("overrun_no_ferr", frame_err, 1'b0);
        // The ignored shift must not have advanced the counter.
        applyStimulus(vecs[2], 1'b0);

        // Reset in the middle of a decode.
        shiftFrame(vecs[1].frame, 64, 1'b0, 1'b1, toExp(vecs[1]));
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_hex", hex, 32'h0);
        checkOutput("midrst_blank", {24'h0, blank}, 32'hFF);
        checkOutput("midrst_invalid", {24'h0, invalid}, 32'h0);
        checkOutput("midrst_flags", {valid, frame_err, overrun, busy}, 4'b0000);
        sbQ.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        checkOutput("midrst_hold_hex", hex, 32'h0);
        applyStimulus(vecs[0], 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
